// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for an external up/down counter: clears it, then runs `cycles`
// triangle sweeps 0..limit..1 while checking the counter's feedback every cycle.
module counter_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cycles,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_enable,
    output logic             cnt_dir,
    output logic             cnt_clear,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] sweeps_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_UP,
        S_DOWN,
        S_FIN
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_cycles;
    logic [WIDTH-1:0] r_sweeps;
    logic             r_error;
    logic             r_hold;
    logic             r_cnt_enable;
    logic             r_cnt_dir;
    logic             r_cnt_clear;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_expected_next;
    logic [WIDTH-1:0] w_limit_next;
    logic [WIDTH-1:0] w_cycles_next;
    logic [WIDTH-1:0] w_sweeps_next;
    logic [WIDTH-1:0] w_sweeps_inc;
    logic             w_error_next;
    logic             w_hold_next;
    logic             w_mismatch;

    assign w_sweeps_inc = r_sweeps + ONE;
    assign w_mismatch   = (count != r_expected);

    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_limit_next    = r_limit;
        w_cycles_next   = r_cycles;
        w_sweeps_next   = r_sweeps;
        w_error_next    = r_error;
        w_hold_next     = r_hold;

        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
            w_hold_next  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_limit_next  = limit;
                        w_cycles_next = cycles;
                        w_error_next  = 1'b0;
                        w_sweeps_next = '0;
                        // Degenerate runs wait one extra FIN cycle so done keeps the 2+2*L*C latency.
                        if ((limit == '0) || (cycles == '0)) begin
                            w_state_next = S_FIN;
                            w_hold_next  = 1'b1;
                        end else begin
                            w_state_next = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    w_expected_next = '0;
                    w_state_next    = S_UP;
                end
                S_UP: begin
                    if (w_mismatch) begin
                        w_error_next = 1'b1;
                        w_state_next = S_FIN;
                    end else begin
                        w_expected_next = r_expected + ONE;
                        if (r_expected == (r_limit - ONE)) begin
                            w_state_next = S_DOWN;
                        end
                    end
                end
                S_DOWN: begin
                    if (w_mismatch) begin
                        w_error_next = 1'b1;
                        w_state_next = S_FIN;
                    end else begin
                        w_expected_next = r_expected - ONE;
                        if (r_expected == ONE) begin
                            w_sweeps_next = w_sweeps_inc;
                            w_state_next  = (w_sweeps_inc == r_cycles) ? S_FIN : S_UP;
                        end
                    end
                end
                S_FIN: begin
                    if (r_hold) begin
                        w_hold_next = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_hold_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_expected   <= '0;
            r_limit      <= '0;
            r_cycles     <= '0;
            r_sweeps     <= '0;
            r_error      <= 1'b0;
            r_hold       <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_cnt_dir    <= 1'b1;
            r_cnt_clear  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_expected   <= w_expected_next;
            r_limit      <= w_limit_next;
            r_cycles     <= w_cycles_next;
            r_sweeps     <= w_sweeps_next;
            r_error      <= w_error_next;
            r_hold       <= w_hold_next;
            // Outputs are decoded from the next state so they are registered yet still Moore.
            r_cnt_enable <= (w_state_next == S_UP) || (w_state_next == S_DOWN);
            r_cnt_dir    <= (w_state_next != S_DOWN);
            r_cnt_clear  <= (w_state_next == S_CLEAR);
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= (w_state_next == S_FIN) && !w_hold_next;
        end
    end

    assign cnt_enable  = r_cnt_enable;
    assign cnt_dir     = r_cnt_dir;
    assign cnt_clear   = r_cnt_clear;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign sweeps_done = r_sweeps;

endmodule
